button_conditioner: RTL and testbench

Conditions the raw Basys 3 push buttons (up, down, left, right) before they reach the up/down counter FSM. Each channel has:
- a 2-flop synchronizer
- a stable-window debouncer
- one-cycle press and release pulses
- an optional auto-repeat pulse train while the button is held

The FSM consumes btn_event, so a held button steps counter2 at a controlled rate.

---
 rtl/btn_pkg.sv | 29 ++
 rtl/button_channel.sv | 130 +++++++++++++
 rtl/button_conditioner.sv | 56 +++++
 tb/tb_button_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and default timings for the push-button
//                conditioning chain (100 MHz system clock).
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Auto-repeat sequencer states for one button channel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Default timings at 100 MHz
    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

    // Larger of two integers, used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One push-button channel: 2-flop synchronizer, stable-window
//                debouncer with press/release pulses, and an auto-repeat
//                sequencer that emits a pulse train while the button is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    rep_state_t    state;

    logic accept;
    logic accept_rise;
    logic accept_fall;

    // The debounced level changes on this edge; the repeat sequencer reacts on
    // the same edge so its first pulse lands exactly REPEAT_DELAY after press.
    assign accept      = (sync2 != btn_level) && (dcnt == DC_LAST);
    assign accept_rise = accept &  sync2;
    assign accept_fall = accept & ~sync2;

    // Two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Stable-window debouncer; any return to the current level restarts the window
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (sync2 == btn_level) begin
                dcnt <= '0;
            end else if (dcnt != DC_LAST) begin
                dcnt <= dcnt + DW'(1);
            end else begin
                dcnt        <= '0;
                btn_level   <= sync2;
                btn_press   <= sync2;
                btn_release <= ~sync2;
            end
        end
    end

    // Auto-repeat sequencer; leaving (release or disable) wins over a due pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rcnt       <= '0;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_rise && repeat_en) begin
                        state <= DELAY;
                        rcnt  <= '0;
                    end
                end
                DELAY: begin
                    if (!repeat_en || accept_fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == RD_LAST) begin
                        state      <= REPEAT;
                        rcnt       <= '0;
                        btn_repeat <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                REPEAT: begin
                    if (!repeat_en || accept_fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == RP_LAST) begin
                        rcnt       <= '0;
                        btn_repeat <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : N_BTN independent button channels plus a registered event
//                stream (press or repeat) for the up/down counter FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_event
);

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            button_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .btn_raw     (btn_raw[i]),
                .repeat_en   (repeat_en[i]),
                .btn_level   (btn_level[i]),
                .btn_press   (btn_press[i]),
                .btn_release (btn_release[i]),
                .btn_repeat  (btn_repeat[i])
            );
        end
    endgenerate

    // Merged step request for the counter FSM, one cycle behind the pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_event <= '0;
        end else begin
            btn_event <= btn_press | btn_repeat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                short timings (debounce 4, repeat delay 10, period 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;
    logic [3:0] btn_event;

    int vectors     = 0;
    int miscompares = 0;

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .btn_event   (btn_event)
    );

    always #5 clk = ~clk;

    // Outputs are sampled, and inputs changed, on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        btn_raw = 4'h0;
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        reset     = 1'b1;
        btn_raw   = 4'hF;
        repeat_en = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== 20'h0) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d got lvl/prs/rel/rep/evt=%h expected 00000",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event});
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp = {(c >= 6) ? 4'hF : 4'h0, (c == 6) ? 4'hF : 4'h0, 4'h0, 4'h0,
                   (c == 7) ? 4'hF : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL reset_release_press c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
        end
        btn_raw = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = {(c < 6) ? 4'hF : 4'h0, 4'h0, (c == 6) ? 4'hF : 4'h0, 4'h0, 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL reset_release_all c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [19:0] exp;
        repeat_en = 4'h0;
        btn_raw   = 4'h1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = {(c >= 6) ? 4'h1 : 4'h0, (c == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0,
                   (c == 7) ? 4'h1 : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL clean_press c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
        end
        btn_raw = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = {(c < 6) ? 4'h1 : 4'h0, 4'h0, (c == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL clean_release c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        btn_raw = 4'h2;
        for (int c = 1; c <= 14; c++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== 20'h0) begin
                miscompares++;
                $display("FAIL glitch c=%0d got %h expected 00000",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event});
            end
            if (c == 3) btn_raw = 4'h0;
        end
    endtask

    task automatic test_bounce();
        logic [19:0] exp;
        btn_raw = 4'h4;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = {(c >= 10) ? 4'h4 : 4'h0, (c == 10) ? 4'h4 : 4'h0, 4'h0, 4'h0,
                   (c == 11) ? 4'h4 : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL bounce c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
            if (c <= 4) btn_raw = (c % 2 == 0) ? 4'h4 : 4'h0;
        end
        settle();
    endtask

    task automatic test_repeat();
        logic [19:0] exp;
        logic        rep;
        logic        evt;
        repeat_en = 4'h8;
        btn_raw   = 4'h8;
        for (int c = 1; c <= 50; c++) begin
            tick();
            rep = (c >= 16) && (c <= 41) && ((c - 16) % 3 == 0);
            evt = (c == 7) || ((c >= 17) && (c <= 42) && ((c - 17) % 3 == 0));
            exp = {(c >= 6 && c < 42) ? 4'h8 : 4'h0, (c == 6) ? 4'h8 : 4'h0,
                   (c == 42) ? 4'h8 : 4'h0, rep ? 4'h8 : 4'h0, evt ? 4'h8 : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL repeat_train c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
            if (c == 36) btn_raw = 4'h0;
        end
        repeat_en = 4'h0;
    endtask

    task automatic test_enable_drop();
        logic [19:0] exp;
        repeat_en = 4'h1;
        btn_raw   = 4'h1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp = {(c >= 6) ? 4'h1 : 4'h0, (c == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0,
                   (c == 7) ? 4'h1 : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL enable_drop c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
            if (c == 10) repeat_en = 4'h0;
            if (c == 12) repeat_en = 4'h1;
        end
        settle();
        repeat_en = 4'h0;
    endtask

    task automatic test_reset_in_repeat();
        logic [19:0] exp;
        logic        rep;
        logic        evt;
        repeat_en = 4'h8;
        btn_raw   = 4'h8;
        for (int c = 1; c <= 20; c++) begin
            tick();
            rep = (c == 16) || (c == 19);
            evt = (c == 7) || (c == 17) || (c == 20);
            exp = {(c >= 6) ? 4'h8 : 4'h0, (c == 6) ? 4'h8 : 4'h0, 4'h0,
                   rep ? 4'h8 : 4'h0, evt ? 4'h8 : 4'h0};
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== exp) begin
                miscompares++;
                $display("FAIL pre_reset_repeat c=%0d got %h expected %h",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event}, exp);
            end
        end
        reset   = 1'b1;
        btn_raw = 4'h0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_repeat, btn_event} !== 20'h0) begin
                miscompares++;
                $display("FAIL reset_in_repeat c=%0d got %h expected 00000",
                         c, {btn_level, btn_press, btn_release, btn_repeat, btn_event});
            end
            if (c == 2) reset = 1'b0;
        end
        repeat_en = 4'h0;
    endtask

    initial begin
        reset     = 1'b1;
        btn_raw   = 4'h0;
        repeat_en = 4'h0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_repeat();
        settle();
        test_enable_drop();
        test_reset_in_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
